// File: rtl/ocp_boot_copier.sv
//------------------------------------------------------------------------------
// Module      : ocp_boot_copier
// Description : OCP master that shadows a block of 32-bit words from a
//               read-only source slave (boot ROM) into a destination slave
//               (on-chip RAM). Each word is one OCP read then one OCP write;
//               only one port is active at a time.
// Revision    : 1.0 - initial release
//------------------------------------------------------------------------------
// Ports:
//   clk, nrst          clock; asynchronous active-low reset
//   i_start            one-cycle start pulse (sampled only when idle)
//   i_src_addr         source byte address ([1:0] ignored)
//   i_dst_addr         destination byte address ([1:0] ignored)
//   i_nwords           number of words to copy (0 = no bus traffic)
//   o_busy             high from the cycle after an accepted start until
//                      the done pulse
//   o_done             one-cycle completion pulse
//   o_err              sticky error flag, cleared by the next accepted start
//   o_src_M*/i_src_S*  source OCP master port (read only)
//   o_dst_M*/i_dst_S*  destination OCP master port (write only)
//   o_csum             running 32-bit sum of words read (optional)
//
// Build option:
//   BOOT_COPIER_CHECKSUM_EN  when defined, adds the o_csum output and adder.
//------------------------------------------------------------------------------
`default_nettype none

`ifndef ADDR_WIDTH
`define ADDR_WIDTH 32
`endif
`ifndef DATA_WIDTH
`define DATA_WIDTH 32
`endif
`ifndef BEN_WIDTH
`define BEN_WIDTH 4
`endif
`ifndef OCP_CMD_IDLE
`define OCP_CMD_IDLE 3'b000
`endif
`ifndef OCP_CMD_WRITE
`define OCP_CMD_WRITE 3'b001
`endif
`ifndef OCP_CMD_READ
`define OCP_CMD_READ 3'b010
`endif
`ifndef OCP_RESP_NULL
`define OCP_RESP_NULL 2'b00
`endif
`ifndef OCP_RESP_DVA
`define OCP_RESP_DVA 2'b01
`endif
`ifndef OCP_RESP_ERR
`define OCP_RESP_ERR 2'b11
`endif

module ocp_boot_copier #(
  parameter int CNT_WIDTH = 16
) (
  input  logic                   clk,
  input  logic                   nrst,
  input  logic                   i_start,
  input  logic [`ADDR_WIDTH-1:0] i_src_addr,
  input  logic [`ADDR_WIDTH-1:0] i_dst_addr,
  input  logic [CNT_WIDTH-1:0]   i_nwords,
  output logic                   o_busy,
  output logic                   o_done,
  output logic                   o_err,
  output logic [`ADDR_WIDTH-1:0] o_src_MAddr,
  output logic [2:0]             o_src_MCmd,
  input  logic                   i_src_SCmdAccept,
  input  logic [`DATA_WIDTH-1:0] i_src_SData,
  input  logic [1:0]             i_src_SResp,
  output logic [`ADDR_WIDTH-1:0] o_dst_MAddr,
  output logic [2:0]             o_dst_MCmd,
  output logic [`DATA_WIDTH-1:0] o_dst_MData,
  output logic [`BEN_WIDTH-1:0]  o_dst_MByteEn,
  input  logic                   i_dst_SCmdAccept,
  input  logic [1:0]             i_dst_SResp
`ifdef BOOT_COPIER_CHECKSUM_EN
  ,
  output logic [`DATA_WIDTH-1:0] o_csum
`endif
);

  localparam logic [2:0] c_CMD_IDLE  = `OCP_CMD_IDLE;
  localparam logic [2:0] c_CMD_WRITE = `OCP_CMD_WRITE;
  localparam logic [2:0] c_CMD_READ  = `OCP_CMD_READ;
  localparam logic [1:0] c_RESP_DVA  = `OCP_RESP_DVA;
  localparam logic [1:0] c_RESP_ERR  = `OCP_RESP_ERR;

  // Word alignment: the two byte-offset bits are forced to zero.
  localparam logic [`ADDR_WIDTH-1:0] c_ADDR_ALIGN = {{(`ADDR_WIDTH-2){1'b1}}, 2'b00};
  localparam logic [`ADDR_WIDTH-1:0] c_WORD_BYTES = `ADDR_WIDTH'(4);
  localparam logic [CNT_WIDTH-1:0]   c_CNT_ONE    = CNT_WIDTH'(1);

  typedef enum logic [2:0] {
    S_IDLE    = 3'd0,
    S_RD_REQ  = 3'd1,
    S_RD_WAIT = 3'd2,
    S_WR_REQ  = 3'd3,
    S_WR_WAIT = 3'd4,
    S_DONE    = 3'd5
  } state_t;

  state_t                  r_state;
  state_t                  w_state_next;
  logic [`ADDR_WIDTH-1:0]  r_src_ptr;
  logic [`ADDR_WIDTH-1:0]  w_src_ptr_next;
  logic [`ADDR_WIDTH-1:0]  r_dst_ptr;
  logic [`ADDR_WIDTH-1:0]  w_dst_ptr_next;
  logic [CNT_WIDTH-1:0]    r_cnt;
  logic [CNT_WIDTH-1:0]    w_cnt_next;
  logic [`DATA_WIDTH-1:0]  r_data;
  logic [`DATA_WIDTH-1:0]  w_data_next;
  logic                    w_err_next;
`ifdef BOOT_COPIER_CHECKSUM_EN
  logic [`DATA_WIDTH-1:0]  w_csum_next;
`endif

  //----------------------------------------------------------------------------
  // Next-state and datapath
  //----------------------------------------------------------------------------
  always_comb begin
    w_state_next   = r_state;
    w_src_ptr_next = r_src_ptr;
    w_dst_ptr_next = r_dst_ptr;
    w_cnt_next     = r_cnt;
    w_data_next    = r_data;
    w_err_next     = o_err;
`ifdef BOOT_COPIER_CHECKSUM_EN
    w_csum_next    = o_csum;
`endif

    case (r_state)
      S_IDLE: begin
        if (i_start) begin
          w_src_ptr_next = i_src_addr & c_ADDR_ALIGN;
          w_dst_ptr_next = i_dst_addr & c_ADDR_ALIGN;
          w_cnt_next     = i_nwords;
          w_err_next     = 1'b0;
`ifdef BOOT_COPIER_CHECKSUM_EN
          w_csum_next    = '0;
`endif
          w_state_next   = (i_nwords == '0) ? S_DONE : S_RD_REQ;
        end
      end

      S_RD_REQ: begin
        if (i_src_SCmdAccept) begin
          w_state_next = S_RD_WAIT;
        end
      end

      S_RD_WAIT: begin
        // Any other response code (NULL, FAIL) keeps waiting.
        if (i_src_SResp == c_RESP_DVA) begin
          w_data_next  = i_src_SData;
`ifdef BOOT_COPIER_CHECKSUM_EN
          w_csum_next  = o_csum + i_src_SData;
`endif
          w_state_next = S_WR_REQ;
        end else if (i_src_SResp == c_RESP_ERR) begin
          w_err_next   = 1'b1;
          w_state_next = S_DONE;
        end
      end

      S_WR_REQ: begin
        if (i_dst_SCmdAccept) begin
          w_state_next = S_WR_WAIT;
        end
      end

      S_WR_WAIT: begin
        if (i_dst_SResp == c_RESP_DVA) begin
          // Pointers wrap naturally at the address width.
          w_src_ptr_next = r_src_ptr + c_WORD_BYTES;
          w_dst_ptr_next = r_dst_ptr + c_WORD_BYTES;
          w_cnt_next     = r_cnt - c_CNT_ONE;
          w_state_next   = (r_cnt == c_CNT_ONE) ? S_DONE : S_RD_REQ;
        end else if (i_dst_SResp == c_RESP_ERR) begin
          w_err_next   = 1'b1;
          w_state_next = S_DONE;
        end
      end

      S_DONE: begin
        w_state_next = S_IDLE;
      end

      default: begin
        w_state_next = S_IDLE;
      end
    endcase
  end

  //----------------------------------------------------------------------------
  // State and registered outputs. Bus outputs are derived from the next state
  // so the command is on the wire during the whole REQ state and drops to
  // IDLE in the cycle after the accept. o_done follows the DONE state by one
  // cycle, which makes o_busy fall exactly as o_done rises.
  //----------------------------------------------------------------------------
  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      r_state       <= S_IDLE;
      r_src_ptr     <= '0;
      r_dst_ptr     <= '0;
      r_cnt         <= '0;
      r_data        <= '0;
      o_busy        <= 1'b0;
      o_done        <= 1'b0;
      o_err         <= 1'b0;
      o_src_MAddr   <= '0;
      o_src_MCmd    <= c_CMD_IDLE;
      o_dst_MAddr   <= '0;
      o_dst_MCmd    <= c_CMD_IDLE;
      o_dst_MData   <= '0;
      o_dst_MByteEn <= '0;
`ifdef BOOT_COPIER_CHECKSUM_EN
      o_csum        <= '0;
`endif
    end else begin
      r_state       <= w_state_next;
      r_src_ptr     <= w_src_ptr_next;
      r_dst_ptr     <= w_dst_ptr_next;
      r_cnt         <= w_cnt_next;
      r_data        <= w_data_next;
      o_busy        <= (w_state_next != S_IDLE);
      o_done        <= (r_state == S_DONE);
      o_err         <= w_err_next;
      o_src_MCmd    <= (w_state_next == S_RD_REQ) ? c_CMD_READ : c_CMD_IDLE;
      o_src_MAddr   <= (w_state_next == S_RD_REQ) ? w_src_ptr_next : '0;
      o_dst_MCmd    <= (w_state_next == S_WR_REQ) ? c_CMD_WRITE : c_CMD_IDLE;
      o_dst_MAddr   <= (w_state_next == S_WR_REQ) ? w_dst_ptr_next : '0;
      o_dst_MData   <= (w_state_next == S_WR_REQ) ? w_data_next : '0;
      o_dst_MByteEn <= (w_state_next == S_WR_REQ) ? {`BEN_WIDTH{1'b1}} : '0;
`ifdef BOOT_COPIER_CHECKSUM_EN
      o_csum        <= w_csum_next;
`endif
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_ocp_boot_copier.sv
//------------------------------------------------------------------------------
// Module      : tb_ocp_boot_copier
// Description : Scoreboard bench for ocp_boot_copier. Stimulus pushes the
//               expected reads, writes and completion records; a monitor pops
//               and compares whenever the DUT issues a command or o_done.
// Revision    : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module tb_ocp_boot_copier;

  localparam logic [2:0] CMD_IDLE = 3'd0;
  localparam logic [2:0] CMD_WR   = 3'd1;
  localparam logic [2:0] CMD_RD   = 3'd2;
  localparam logic [1:0] R_NULL   = 2'd0;
  localparam logic [1:0] R_DVA    = 2'd1;
  localparam logic [1:0] R_ERR    = 2'd3;

  logic        clk = 1'b0;
  logic        nrst = 1'b0;
  logic        i_start = 1'b0;
  logic [31:0] i_src_addr = '0;
  logic [31:0] i_dst_addr = '0;
  logic [15:0] i_nwords = '0;
  logic        o_busy, o_done, o_err;
  logic [31:0] o_src_MAddr;
  logic [2:0]  o_src_MCmd;
  logic        src_acc;
  logic [31:0] src_data = '0;
  logic [1:0]  src_resp = R_NULL;
  logic [31:0] o_dst_MAddr;
  logic [2:0]  o_dst_MCmd;
  logic [31:0] o_dst_MData;
  logic [3:0]  o_dst_MByteEn;
  logic        dst_acc;
  logic [1:0]  dst_resp = R_NULL;
`ifdef BOOT_COPIER_CHECKSUM_EN
  logic [31:0] o_csum;
`endif

  ocp_boot_copier #(.CNT_WIDTH(16)) dut (
    .clk              (clk),
    .nrst             (nrst),
    .i_start          (i_start),
    .i_src_addr       (i_src_addr),
    .i_dst_addr       (i_dst_addr),
    .i_nwords         (i_nwords),
    .o_busy           (o_busy),
    .o_done           (o_done),
    .o_err            (o_err),
    .o_src_MAddr      (o_src_MAddr),
    .o_src_MCmd       (o_src_MCmd),
    .i_src_SCmdAccept (src_acc),
    .i_src_SData      (src_data),
    .i_src_SResp      (src_resp),
    .o_dst_MAddr      (o_dst_MAddr),
    .o_dst_MCmd       (o_dst_MCmd),
    .o_dst_MData      (o_dst_MData),
    .o_dst_MByteEn    (o_dst_MByteEn),
    .i_dst_SCmdAccept (dst_acc),
    .i_dst_SResp      (dst_resp)
`ifdef BOOT_COPIER_CHECKSUM_EN
    ,
    .o_csum           (o_csum)
`endif
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  //----------------------------------------------------------------------------
  // Slave models: ROM indexed by address[5:2], always-accept source with a
  // next-cycle response, destination with an optional 5-cycle accept stall.
  //----------------------------------------------------------------------------
  logic [31:0] rom [16];
  int rd_seen = 0, wr_seen = 0, hold_cnt = 0;
  int err_idx = -1, stall_idx = -1;

  assign src_acc = 1'b1;
  assign dst_acc = !((wr_seen == stall_idx) && (hold_cnt < 5));

  always @(posedge clk) begin
    src_resp <= R_NULL;
    dst_resp <= R_NULL;
    if (!o_busy) begin
      rd_seen  <= 0;
      wr_seen  <= 0;
      hold_cnt <= 0;
    end else begin
      if (o_src_MCmd == CMD_RD && src_acc) begin
        src_resp <= (rd_seen == err_idx) ? R_ERR : R_DVA;
        src_data <= rom[o_src_MAddr[5:2]];
        rd_seen  <= rd_seen + 1;
      end
      if (o_dst_MCmd == CMD_WR) begin
        if (dst_acc) begin
          dst_resp <= R_DVA;
          wr_seen  <= wr_seen + 1;
          hold_cnt <= 0;
        end else begin
          hold_cnt <= hold_cnt + 1;
        end
      end
    end
  end

  //----------------------------------------------------------------------------
  // Scoreboard
  //----------------------------------------------------------------------------
  typedef struct packed {logic [31:0] addr; logic [31:0] data;} wr_t;
  typedef struct {int delta; logic err; logic [31:0] csum;} done_t;

  logic [31:0] exp_rd[$];
  wr_t         exp_wr[$];
  done_t       exp_done[$];
  int checks = 0, errors = 0, start_cyc = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic push_wr(input logic [31:0] a, input logic [31:0] d);
    wr_t w;
    w.addr = a;
    w.data = d;
    exp_wr.push_back(w);
  endtask

  task automatic push_done(input int delta, input logic e, input logic [31:0] c);
    done_t r;
    r.delta = delta;
    r.err   = e;
    r.csum  = c;
    exp_done.push_back(r);
  endtask

  always @(negedge clk) begin
    if (nrst) begin
      if (o_src_MCmd == CMD_RD && src_acc) begin
        check("read expected", 64'(exp_rd.size() != 0), 64'd1);
        if (exp_rd.size() != 0) check("read addr", o_src_MAddr, exp_rd.pop_front());
      end
      if (o_dst_MCmd == CMD_WR) begin
        check("write expected", 64'(exp_wr.size() != 0), 64'd1);
        if (exp_wr.size() != 0) begin
          // Compared on every cycle the write is held, so a stall also
          // verifies address/data stability.
          check("write addr", o_dst_MAddr, exp_wr[0].addr);
          check("write data", o_dst_MData, exp_wr[0].data);
          check("write byteen", o_dst_MByteEn, 64'hF);
          if (dst_acc) void'(exp_wr.pop_front());
        end
      end
      if (o_done) begin
        check("done expected", 64'(exp_done.size() != 0), 64'd1);
        if (exp_done.size() != 0) begin
          done_t r;
          r = exp_done.pop_front();
          check("done latency", 64'(cyc - start_cyc), 64'(r.delta));
          check("done err", o_err, r.err);
          check("busy low at done", o_busy, 1'b0);
`ifdef BOOT_COPIER_CHECKSUM_EN
          check("csum", o_csum, r.csum);
`endif
        end
      end
    end
  end

  //----------------------------------------------------------------------------
  // Stimulus helpers
  //----------------------------------------------------------------------------
  task automatic start_copy(input logic [31:0] s, input logic [31:0] d, input logic [15:0] n);
    @(negedge clk);
    i_src_addr = s;
    i_dst_addr = d;
    i_nwords   = n;
    i_start    = 1'b1;
    start_cyc  = cyc;
    @(negedge clk);
    i_start    = 1'b0;
  endtask

  task automatic wait_done(input string name, input int budget);
    int k = 0;
    while (exp_done.size() != 0 && k < budget) begin
      @(negedge clk);
      k++;
    end
    check({name, " completed in time"}, 64'(exp_done.size() == 0), 64'd1);
    repeat (2) @(negedge clk);
  endtask

  task automatic check_idle_outputs(input string tag);
    check({tag, " busy"}, o_busy, 1'b0);
    check({tag, " done"}, o_done, 1'b0);
    check({tag, " err"}, o_err, 1'b0);
    check({tag, " src cmd/addr"}, {o_src_MCmd, o_src_MAddr}, {CMD_IDLE, 32'h0});
    check({tag, " dst cmd/addr"}, {o_dst_MCmd, o_dst_MAddr}, {CMD_IDLE, 32'h0});
    check({tag, " dst data/ben"}, {o_dst_MData, o_dst_MByteEn}, 64'h0);
`ifdef BOOT_COPIER_CHECKSUM_EN
    check({tag, " csum"}, o_csum, 32'h0);
`endif
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish, checks=%0d", checks);
    $fatal(1, "watchdog");
  end

  initial begin
    int k;
    for (int i = 0; i < 16; i++) rom[i] = 32'hDEAD_0000 + 32'(i);
    rom[0]  = 32'h1111_1111;
    rom[1]  = 32'h2222_2222;
    rom[2]  = 32'h3333_3333;
    rom[3]  = 32'h4444_4444;
    rom[15] = 32'hFFFF_0000;

    // Reset state
    nrst = 1'b0;
    repeat (3) @(negedge clk);
    check_idle_outputs("reset");
    nrst = 1'b1;
    @(negedge clk);

    // Basic 3-word copy
    exp_rd.push_back(32'h0); exp_rd.push_back(32'h4); exp_rd.push_back(32'h8);
    push_wr(32'h1000, 32'h1111_1111);
    push_wr(32'h1004, 32'h2222_2222);
    push_wr(32'h1008, 32'h3333_3333);
    push_done(14, 1'b0, 32'h6666_6666);
    start_copy(32'h0, 32'h1000, 16'd3);
    wait_done("basic", 60);

    // Zero-length copy: no bus traffic, busy for one cycle
    push_done(2, 1'b0, 32'h0);
    start_copy(32'h0, 32'h7000, 16'd0);
    check("n0 busy cycle1", o_busy, 1'b1);
    @(negedge clk);
    check("n0 busy cycle2", o_busy, 1'b0);
    check("n0 done cycle2", o_done, 1'b1);
    wait_done("n0", 10);

    // Destination stall of 5 cycles on the second write
    stall_idx = 1;
    exp_rd.push_back(32'h4); exp_rd.push_back(32'h8); exp_rd.push_back(32'hC);
    push_wr(32'h3000, 32'h2222_2222);
    push_wr(32'h3004, 32'h3333_3333);
    push_wr(32'h3008, 32'h4444_4444);
    push_done(19, 1'b0, 32'h9999_9999);
    start_copy(32'h4, 32'h3000, 16'd3);
    wait_done("stall", 60);
    stall_idx = -1;

    // Source error on the second read of four
    err_idx = 1;
    exp_rd.push_back(32'h0); exp_rd.push_back(32'h4);
    push_wr(32'h2000, 32'h1111_1111);
    push_done(8, 1'b1, 32'h1111_1111);
    start_copy(32'h0, 32'h2000, 16'd4);
    wait_done("src err", 40);
    err_idx = -1;
    repeat (3) @(negedge clk);
    check("err sticky", o_err, 1'b1);

    // Next start clears the error
    exp_rd.push_back(32'hC);
    push_wr(32'h2100, 32'h4444_4444);
    push_done(6, 1'b0, 32'h4444_4444);
    start_copy(32'hC, 32'h2100, 16'd1);
    check("err cleared by start", o_err, 1'b0);
    wait_done("after err", 30);

    // Address wrap, unaligned inputs, and a start while busy
    exp_rd.push_back(32'hFFFF_FFFC); exp_rd.push_back(32'h0);
    push_wr(32'h4000, 32'hFFFF_0000);
    push_wr(32'h4004, 32'h1111_1111);
    push_done(10, 1'b0, 32'h1110_1111);
    start_copy(32'hFFFF_FFFE, 32'h4003, 16'd2);
    repeat (3) @(negedge clk);
    i_src_addr = 32'h100;
    i_dst_addr = 32'h8000;
    i_nwords   = 16'd5;
    i_start    = 1'b1;
    @(negedge clk);
    i_start    = 1'b0;
    wait_done("wrap", 40);

    // Reset during WR_WAIT of word 2
    exp_rd.push_back(32'h0); exp_rd.push_back(32'h4);
    push_wr(32'h5000, 32'h1111_1111);
    push_wr(32'h5004, 32'h2222_2222);
    start_copy(32'h0, 32'h5000, 16'd3);
    k = 0;
    while (!(o_dst_MCmd == CMD_WR && dst_acc && wr_seen == 1) && k < 50) begin
      @(negedge clk);
      k++;
    end
    check("second write reached", 64'(k < 50), 64'd1);
    @(posedge clk);
    #2 nrst = 1'b0;
    #1;
    check_idle_outputs("mid-copy reset");
    check("reset reads consumed", 64'(exp_rd.size()), 64'd0);
    check("reset writes consumed", 64'(exp_wr.size()), 64'd0);
    repeat (2) @(negedge clk);
    nrst = 1'b1;
    @(negedge clk);

    // Fresh copy after reset
    exp_rd.push_back(32'h8);
    push_wr(32'h6000, 32'h3333_3333);
    push_done(6, 1'b0, 32'h3333_3333);
    start_copy(32'h8, 32'h6000, 16'd1);
    wait_done("after reset", 30);

    check("leftover reads", 64'(exp_rd.size()), 64'd0);
    check("leftover writes", 64'(exp_wr.size()), 64'd0);
    check("leftover dones", 64'(exp_done.size()), 64'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

`default_nettype wire
